// File: rtl/cla_addsub_pipe.sv
// Pipelined add/subtract built from 4-bit carry-lookahead slices, one slice per stage.
// Operands are skewed in and sums deskewed out, so the full result leaves in one beat.
module cla_addsub_pipe #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             ovf
);

   localparam int unsigned NSL = WIDTH / 4;

   logic adv;
   logic ovf_r;

   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   for (genvar k = 0; k < NSL; k++) begin : g_stage
      // Width of the operand bits still to be added when this stage sees them.
      localparam int unsigned IW = WIDTH - 4 * k;

      logic [IW-1:0]    a_i, b_i;
      logic             c_i, m_i, v_i;
      logic [3:0]       sa, sb, g, p, sum;
      logic [4:0]       c;
      logic [4*k+3:0]   s_n;
      logic             valid_r, carry_r;
      logic [4*k+3:0]   s_r;

      if (k == 0) begin : g_head
         assign a_i = a;
         assign b_i = b;
         assign c_i = mode;
         assign m_i = mode;
         assign v_i = in_valid;
         assign s_n = sum;
      end else begin : g_body
         assign a_i = g_stage[k-1].g_fwd.a_r;
         assign b_i = g_stage[k-1].g_fwd.b_r;
         assign m_i = g_stage[k-1].g_fwd.mode_r;
         assign c_i = g_stage[k-1].carry_r;
         assign v_i = g_stage[k-1].valid_r;
         assign s_n = {sum, g_stage[k-1].s_r};
      end

      always_comb begin
         sa   = a_i[3:0];
         sb   = b_i[3:0] ^ {4{m_i}};
         g    = sa & sb;
         p    = sa ^ sb;
         c[0] = c_i;
         c[1] = g[0] | (p[0] & c_i);
         c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_i);
         c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_i);
         c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c_i);
         sum  = p ^ c[3:0];
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            valid_r <= 1'b0;
            carry_r <= 1'b0;
            s_r     <= '0;
         end else if (adv) begin
            valid_r <= v_i;
            carry_r <= c[4];
            s_r     <= s_n;
         end
      end

      // Upper operand slices and the op's mode ride along to the next stage.
      if (k < NSL - 1) begin : g_fwd
         logic [IW-5:0] a_r, b_r;
         logic          mode_r;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               a_r    <= '0;
               b_r    <= '0;
               mode_r <= 1'b0;
            end else if (adv) begin
               a_r    <= a_i[IW-1:4];
               b_r    <= b_i[IW-1:4];
               mode_r <= m_i;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_r <= 1'b0;
      end else if (adv) begin
         ovf_r <= g_stage[NSL-1].c[3] ^ g_stage[NSL-1].c[4];
      end
   end

   assign out_valid = g_stage[NSL-1].valid_r;
   assign s         = g_stage[NSL-1].s_r;
   assign cout      = g_stage[NSL-1].carry_r;
   assign ovf       = ovf_r;

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Bench for cla_addsub_pipe: directed literal cases plus randomized traffic against an
// arithmetic reference model and an in-order scoreboard.
module tb_cla_addsub_pipe;

   localparam int unsigned W = 16;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         mode = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] s;
   logic         cout;
   logic         ovf;

   int checks = 0;
   int failures = 0;
   int npop = 0;

   logic [W+1:0] q[$];
   logic         hold = 1'b0;
   logic [W+1:0] held = '0;

   cla_addsub_pipe #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .a        (a),
      .b        (b),
      .mode     (mode),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .s        (s),
      .cout     (cout),
      .ovf      (ovf)
   );

   always #5 clk = ~clk;

   // Returns {ovf, cout, s} from plain integer arithmetic.
   function automatic logic [W+1:0] model(input logic [W-1:0] xa, input logic [W-1:0] xb,
                                          input logic xm);
      logic [W:0] r;
      logic       v;
      if (xm) r = {1'b0, xa} + {1'b0, ~xb} + 1;
      else    r = {1'b0, xa} + {1'b0, xb};
      if (xm) v = (xa[W-1] != xb[W-1]) && (r[W-1] != xa[W-1]);
      else    v = (xa[W-1] == xb[W-1]) && (r[W-1] != xa[W-1]);
      return {v, r[W], r[W-1:0]};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Scoreboard: every accepted op is queued; every consumed result must match the head.
   always @(negedge clk) begin
      if (!rst_n) begin
         q.delete();
         hold = 1'b0;
      end else begin
         chk("in_ready", {31'b0, in_ready}, {31'b0, (!out_valid || out_ready)});
         if (hold) begin
            chk("hold_valid", {31'b0, out_valid}, 32'd1);
            chk("hold_data", {14'b0, ovf, cout, s}, {14'b0, held});
         end
         hold = out_valid && !out_ready;
         held = {ovf, cout, s};
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               chk("spurious_out", {31'b0, out_valid}, 32'd0);
            end else begin
               chk("result", {14'b0, ovf, cout, s}, {14'b0, q.pop_front()});
               npop++;
            end
         end
         if (in_valid && in_ready) q.push_back(model(a, b, mode));
      end
   end

   // Single op on an idle pipe; checks latency and literal result.
   task automatic directed(input string name, input logic [W-1:0] xa, input logic [W-1:0] xb,
                           input logic xm, input logic [W-1:0] es, input logic ec,
                           input logic eo);
      int n;
      in_valid  = 1'b1;
      a         = xa;
      b         = xb;
      mode      = xm;
      out_ready = 1'b1;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         n++;
      end while (!out_valid && n < 20);
      chk({name, "_latency"}, n, 32'd4);
      chk({name, "_s"}, {16'b0, s}, {16'b0, es});
      chk({name, "_cout"}, {31'b0, cout}, {31'b0, ec});
      chk({name, "_ovf"}, {31'b0, ovf}, {31'b0, eo});
      repeat (6) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xm);
      logic acc;
      int   tries;
      in_valid = 1'b1;
      a        = xa;
      b        = xb;
      mode     = xm;
      tries    = 0;
      do begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         tries++;
      end while (!acc && tries < 50);
      if (!acc) chk("send_timeout", {31'b0, acc}, 32'd1);
      in_valid = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int p0;

      #2;
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_s", {16'b0, s}, 32'd0);
      chk("rst_cout_ovf", {30'b0, cout, ovf}, 32'd0);
      chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Pin the reference model itself.
      chk("model_add", {14'b0, model(16'h1234, 16'h0FFF, 1'b0)}, {14'b0, 2'b00, 16'h2233});
      chk("model_sub", {14'b0, model(16'h8000, 16'h0001, 1'b1)}, {14'b0, 2'b11, 16'h7FFF});

      directed("add1", 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0);
      directed("sub2", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      directed("sub3", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
      directed("add4", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);

      // Eight back-to-back ops with a three-cycle output stall mid-stream.
      p0 = npop;
      fork
         begin
            for (int i = 0; i < 8; i++) send(W'($urandom), W'($urandom), 1'($urandom));
         end
         begin
            repeat (6) @(posedge clk);
            #1;
            out_ready = 1'b0;
            for (int i = 0; i < 3; i++) begin
               #1;
               chk("stall_valid", {31'b0, out_valid}, 32'd1);
               chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
               @(posedge clk);
               #1;
            end
            out_ready = 1'b1;
         end
      join
      repeat (10) @(posedge clk);
      #1;
      chk("burst_count", npop - p0, 32'd8);

      // Reset with one result at the output and three ops in flight.
      for (int i = 0; i < 4; i++) send(W'($urandom), W'($urandom), 1'($urandom));
      chk("pre_rst_valid", {31'b0, out_valid}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", {31'b0, out_valid}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         chk("no_stale", {31'b0, out_valid}, 32'd0);
      end
      directed("post_rst", 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0);

      // Randomized traffic with random backpressure.
      p0 = npop;
      for (int i = 0; i < 400; i++) begin
         in_valid  = ($urandom_range(9) < 7);
         a         = W'($urandom);
         b         = W'($urandom);
         mode      = 1'($urandom);
         out_ready = ($urandom_range(9) < 7);
         @(posedge clk);
         #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      chk("drain_empty", q.size(), 32'd0);
      chk("random_progress", {31'b0, (npop - p0 > 100)}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
